// File: rtl/xunit_f_if.sv
// Job/data bundle of the xunit_f SHA-256 round engine: start pulse, chaining words,
// W[t] stream in, result words and done out. Lane 0 of i_in/o_out is word a/H0.
interface xunit_f_if #(
    parameter int DATA_W = 32
);
    logic                     i_run;
    logic [7:0]               i_delay0;
    logic [7:0][DATA_W-1:0]   i_in;
    logic [DATA_W-1:0]        i_in8;
    logic [7:0][DATA_W-1:0]   o_out;
    logic                     o_done;

    modport master (
        output i_run, i_delay0, i_in, i_in8,
        input  o_out, o_done
    );

    modport slave (
        input  i_run, i_delay0, i_in, i_in8,
        output o_out, o_done
    );
endinterface

// File: rtl/xunit_f.sv
// xunit_f: 64-round SHA-256 compression engine fed one W[t] word per cycle.
// Define XUNIT_F_FEEDFORWARD_EN to add the chaining value H into the outputs.
module xunit_f #(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 10
) (
    input  logic      clk,
    input  logic      rst,
    xunit_f_if.slave  bus
);
    // delay0 is an 8-bit count whatever DELAY_W says
    localparam int DLY_W = (DELAY_W > 0) ? 8 : 8;

    localparam logic [0:63][31:0] K_ROM = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ROUND = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] big_sigma0(input logic [DATA_W-1:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [DATA_W-1:0] big_sigma1(input logic [DATA_W-1:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [DATA_W-1:0] ch(input logic [DATA_W-1:0] e,
                                             input logic [DATA_W-1:0] f,
                                             input logic [DATA_W-1:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [DATA_W-1:0] maj(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DLY_W-1:0]        r_delay;
    logic [5:0]              r_t;
    logic                    r_done;
    logic [7:0][DATA_W-1:0]  r_wv;
    logic [7:0][DATA_W-1:0]  r_out;
    logic [7:0][DATA_W-1:0]  w_cur;
    logic [7:0][DATA_W-1:0]  w_nv;
    logic [7:0][DATA_W-1:0]  w_res;
    logic [DATA_W-1:0]       w_t1;
    logic [DATA_W-1:0]       w_t2;
    logic                    w_last;
`ifdef XUNIT_F_FEEDFORWARD_EN
    logic [7:0][DATA_W-1:0]  r_hs;
`endif

    assign bus.o_out  = r_out;
    assign bus.o_done = r_done;
    assign w_last     = (r_state == ST_ROUND) && (r_t == 6'd63);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a run pulse overrides everything, including a job in flight
    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_run) begin
            w_state_nxt = (bus.i_delay0 != 8'd0) ? ST_WAIT : ST_ROUND;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_IDLE;
                ST_WAIT:  w_state_nxt = (r_delay <= 8'd1) ? ST_ROUND : ST_WAIT;
                ST_ROUND: w_state_nxt = (r_t == 6'd63) ? ST_FIN : ST_ROUND;
                ST_FIN:   w_state_nxt = ST_FIN;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // One compression round; round 0 works straight off the chaining inputs
    always_comb begin
        w_cur = (r_t == 6'd0) ? bus.i_in : r_wv;
        w_t1  = w_cur[7] + big_sigma1(w_cur[4]) + ch(w_cur[4], w_cur[5], w_cur[6])
              + K_ROM[r_t] + bus.i_in8;
        w_t2  = big_sigma0(w_cur[0]) + maj(w_cur[0], w_cur[1], w_cur[2]);
        w_nv[0] = w_t1 + w_t2;
        w_nv[1] = w_cur[0];
        w_nv[2] = w_cur[1];
        w_nv[3] = w_cur[2];
        w_nv[4] = w_cur[3] + w_t1;
        w_nv[5] = w_cur[4];
        w_nv[6] = w_cur[5];
        w_nv[7] = w_cur[6];
        for (int i = 0; i < 8; i++) begin
`ifdef XUNIT_F_FEEDFORWARD_EN
            w_res[i] = r_hs[i] + w_nv[i];
`else
            w_res[i] = w_nv[i];
`endif
        end
    end

    // Job control: wait countdown, round index and done flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_delay <= '0;
            r_t     <= 6'd0;
            r_done  <= 1'b1;
        end else if (bus.i_run) begin
            r_delay <= bus.i_delay0;
            r_t     <= 6'd0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT: r_delay <= r_delay - 8'd1;
                ST_ROUND: begin
                    if (r_t == 6'd63) begin
                        r_t    <= 6'd0;
                        r_done <= 1'b1;
                    end else begin
                        r_t <= r_t + 6'd1;
                    end
                end
                default: r_delay <= r_delay;
            endcase
        end
    end

    // Working registers and result capture; the result loads on round 63 even if run restarts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wv  <= '0;
            r_out <= '0;
`ifdef XUNIT_F_FEEDFORWARD_EN
            r_hs  <= '0;
`endif
        end else begin
            if (r_state == ST_ROUND) begin
                r_wv <= w_nv;
            end
            if (w_last) begin
                r_out <= w_res;
            end
`ifdef XUNIT_F_FEEDFORWARD_EN
            if ((r_state == ST_ROUND) && (r_t == 6'd0)) begin
                r_hs <= bus.i_in;
            end
`endif
        end
    end
endmodule

// File: tb/tb_xunit_f.sv
// Randomized self-checking bench for xunit_f against a plain SHA-256 compression model.
// Honours XUNIT_F_FEEDFORWARD_EN the same way the design does.
module tb_xunit_f;
    typedef logic [7:0][31:0]  vec8_t;
    typedef logic [63:0][31:0] wvec_t;

    localparam logic [0:63][31:0] K_TB = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic  clk = 1'b0;
    logic  rst;
    int    n_pass  = 0;
    int    n_total = 0;
    vec8_t held;
    vec8_t iv;
    wvec_t abc_w;

    xunit_f_if #(.DATA_W(32)) bus ();

    xunit_f #(.DATA_W(32), .DELAY_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Textbook SHA-256 compression of one block given its 64 schedule words
    function automatic vec8_t ref_model(input vec8_t h, input wvec_t w);
        logic [31:0] a, b, c, d, e, f, g, hh, s1, s0, t1, t2;
        vec8_t r;
        a = h[0]; b = h[1]; c = h[2]; d = h[3];
        e = h[4]; f = h[5]; g = h[6]; hh = h[7];
        for (int t = 0; t < 64; t++) begin
            s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
            s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            t1 = hh + s1 + ((e & f) ^ (~e & g)) + K_TB[t] + w[t];
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        r[4] = e; r[5] = f; r[6] = g; r[7] = hh;
`ifdef XUNIT_F_FEEDFORWARD_EN
        for (int i = 0; i < 8; i++) r[i] = r[i] + h[i];
`endif
        return r;
    endfunction

    function automatic vec8_t rand_vec8();
        vec8_t v;
        for (int i = 0; i < 8; i++) v[i] = $urandom();
        return v;
    endfunction

    function automatic wvec_t rand_w();
        wvec_t v;
        for (int i = 0; i < 64; i++) v[i] = $urandom();
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input vec8_t exp);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_out%0d", tag, i), bus.o_out[i], exp[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        for (int i = 0; i < 8; i++) bus.i_in[i] = $urandom();
        bus.i_in8    = $urandom();
        bus.i_delay0 = 8'($urandom());
    endtask

    // Pulse run this cycle, then sit through the configured wait
    task automatic start(input int d);
        scramble();
        bus.i_delay0 = 8'(d);
        bus.i_run    = 1'b1;
        tick();
        bus.i_run    = 1'b0;
        for (int i = 0; i < d; i++) begin
            scramble();
            chk("wait_done", {31'd0, bus.o_done}, 32'd0);
            chk("wait_hold", bus.o_out[0], held[0]);
            tick();
        end
    endtask

    // Feed n round cycles; chaining words only meaningful at t=0
    task automatic rounds(input vec8_t h, input wvec_t w, input int n);
        for (int t = 0; t < n; t++) begin
            scramble();
            if (t == 0) bus.i_in = h;
            bus.i_in8 = w[t];
            chk("busy_done", {31'd0, bus.o_done}, 32'd0);
            chk("busy_hold", bus.o_out[7], held[7]);
            tick();
        end
    endtask

    task automatic job(input vec8_t h, input wvec_t w, input int d, input string tag);
        vec8_t exp;
        exp = ref_model(h, w);
        start(d);
        rounds(h, w, 64);
        chk({tag, "_done"}, {31'd0, bus.o_done}, 32'd1);
        chk_outs(tag, exp);
        held = exp;
    endtask

    task automatic chk_abc_const(input string tag);
`ifdef XUNIT_F_FEEDFORWARD_EN
        chk({tag, "_digest0"}, bus.o_out[0], 32'hba7816bf);
        chk({tag, "_digest7"}, bus.o_out[7], 32'hf20015ad);
`else
        chk({tag, "_raw_a"}, bus.o_out[0], 32'h506e3058);
`endif
    endtask

    initial begin
        vec8_t h1, h2, d1;
        wvec_t w1, w2, zw;

        rst = 1'b1;
        bus.i_run = 1'b0; bus.i_delay0 = 8'd0; bus.i_in = '0; bus.i_in8 = 32'd0;
        held = '0;
        iv = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
              32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
        abc_w = '0;
        abc_w[0]  = 32'h61626380;
        abc_w[15] = 32'h00000018;
        for (int t = 16; t < 64; t++) begin
            abc_w[t] = ssig1(abc_w[t-2]) + abc_w[t-7] + ssig0(abc_w[t-15]) + abc_w[t-16];
        end
        zw = '0;

        repeat (3) tick();
        chk("rst_done", {31'd0, bus.o_done}, 32'd1);
        chk_outs("rst", '0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle_done", {31'd0, bus.o_done}, 32'd1);

        job(iv, abc_w, 0, "abc_d0");
        chk_abc_const("abc_d0");
        repeat (5) begin
            scramble();
            tick();
            chk("fin_done", {31'd0, bus.o_done}, 32'd1);
            chk("fin_hold", bus.o_out[3], held[3]);
        end

        job(iv, abc_w, 17, "abc_d17");
        chk_abc_const("abc_d17");

        for (int k = 0; k < 4; k++) begin
            job(rand_vec8(), rand_w(), (k == 0) ? 1 : int'($urandom_range(0, 6)), $sformatf("rnd%0d", k));
        end

        // Restart in the middle of round 30, then a clean "abc" job
        start(0);
        rounds(rand_vec8(), rand_w(), 30);
        start(0);
        rounds(iv, abc_w, 64);
        chk("restart_done", {31'd0, bus.o_done}, 32'd1);
        chk_abc_const("restart");
        held = ref_model(iv, abc_w);

        // run during the last round: result loads and the next job starts on the same edge
        h1 = rand_vec8(); w1 = rand_w();
        h2 = rand_vec8(); w2 = rand_w();
        start(0);
        rounds(h1, w1, 63);
        scramble();
        bus.i_in8 = w1[63]; bus.i_delay0 = 8'd0; bus.i_run = 1'b1;
        tick();
        bus.i_run = 1'b0;
        held = ref_model(h1, w1);
        chk("b2b_done_low", {31'd0, bus.o_done}, 32'd0);
        chk_outs("b2b_first", held);
        rounds(h2, w2, 64);
        chk("b2b_done", {31'd0, bus.o_done}, 32'd1);
        chk_outs("b2b_second", ref_model(h2, w2));
        held = ref_model(h2, w2);

        // Chain: second job seeded by the first digest with an all-zero schedule
        job(h1, w1, 0, "chain1");
        d1 = ref_model(h1, w1);
        start(0);
        rounds(d1, zw, 64);
        chk("chain2_done", {31'd0, bus.o_done}, 32'd1);
        chk_outs("chain2", ref_model(d1, zw));
        held = ref_model(d1, zw);

        // Asynchronous reset at round 40 aborts the job
        start(0);
        rounds(iv, abc_w, 40);
        rst = 1'b1;
        #1;
        chk("arst_done", {31'd0, bus.o_done}, 32'd1);
        chk_outs("arst", '0);
        @(negedge clk);
        rst = 1'b0;
        held = '0;
        repeat (70) begin
            scramble();
            tick();
            chk("post_rst_done", {31'd0, bus.o_done}, 32'd1);
            chk("post_rst_out", bus.o_out[0], 32'd0);
        end

        job(iv, abc_w, 2, "after_rst");
        chk_abc_const("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/xunit_f.md
XUNIT_F -- requirements
Module: xunit_f

Interface
REQ-001 Parameter: DATA_W, default 32, datapath width; only 32 is supported.
REQ-002 Parameter: DELAY_W, default 10, kept for unit uniformity; not used internally.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 run  input  1  one-cycle start pulse for a 64-round compression.
REQ-006 in0..in7  input  32 each  chaining state H0..H7, sampled at round 0.
REQ-007 in8  input  32  message-schedule word W[t] stream from the upstream schedule unit, one word per cycle.
REQ-008 out0..out7  output  32 each  registered result words.
REQ-009 done  output  1  high when idle or finished, low while a job is pending.
REQ-010 delay0  input  8  configured cycles from run to the arrival of W[0].

Function
REQ-011 States: IDLE, WAIT, ROUND, FIN.
- FIN holds results.
- done=1 in IDLE and FIN, 0 in WAIT and ROUND.
REQ-012 run in any state: delay<=delay0, t<=0, done<=0.
- Go to WAIT if delay0!=0, else ROUND.
- run wins over every other event in the same cycle, including mid-ROUND (restart).
REQ-013 WAIT: decrement delay each cycle; enter ROUND on the cycle delay reaches 0.
- Cycle t=0 is the first ROUND cycle, which is run+delay0+1.
REQ-014 ROUND cycle t (0..63): in8 is taken as W[t] unconditionally, with no valid qualifier.
- At t=0, the working values a..h are in0..in7 (bypass).
- At t=0, in0..in7 are also captured into internal H0..H7.
- For t>0, a..h are the registers.
REQ-015 Per round, all sums are mod 2^32:
- T1 = h + Sigma1(e) + Ch(e,f,g) + K[t] + W[t]
- T2 = Sigma0(a) + Maj(a,b,c)
- h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2
REQ-016 Function definitions:
- Sigma0 = ROTR2^ROTR13^ROTR22.
- Sigma1 = ROTR6^ROTR11^ROTR25.
- Ch = (e&f)^(~e&g).
- Maj = (a&b)^(a&c)^(b&c).
REQ-017 K[0..63] is the FIPS 180-4 SHA-256 constant table, held as a combinational ROM indexed by a 6-bit t.
REQ-018 After round t=63:
- Next cycle, out0..out7 are loaded per REQ-027/028, done<=1, state FIN.
- Latency from W[0] cycle to valid outputs is 64 cycles.
REQ-019 Outputs change only on the FIN-entry cycle and at reset.
- They are held through FIN, IDLE and a subsequent WAIT/ROUND until the next FIN entry.
REQ-020 In IDLE and FIN, in0..in8 are ignored.
REQ-021 t does not wrap: ROUND exits after 63 and never re-enters without run.
REQ-022 Back-to-back jobs: run asserted on the FIN-entry cycle loads outputs and restarts in the same edge.

Reset
REQ-023 While rst is high: state=IDLE, done=1, delay=0, t=0.
REQ-024 While rst is high: a..h=0, H0..H7=0, out0..out7=0.
REQ-025 rst asserted mid-WAIT or mid-ROUND aborts the job; outputs read 0 and no FIN entry follows.
REQ-026 The first run after rst release behaves as from IDLE.

Configuration
REQ-027 Macro XUNIT_F_FEEDFORWARD_EN defined: outN = H_N + working register N (mod 2^32), i.e. the full compression result.
REQ-028 Macro undefined: outN = raw working register N (a..h), with no H capture or adders synthesized; timing is identical.

Verification
REQ-029 FEEDFORWARD_EN, delay0=0, in0..7=SHA-256 IV, in8=W stream of padded "abc" -> at run+65:
- out0=0xba7816bf, out7=0xf20015ad, done rises the same cycle.
REQ-030 Same stimulus without FEEDFORWARD_EN -> out0=0x506e3058 (a only, no IV added).
REQ-031 delay0=17 with the upstream schedule unit chained -> first round at run+18, done at run+82, same digest as REQ-029.
REQ-032 run pulsed again at round 30, then correct "abc" stream -> no FIN at the aborted point; digest matches REQ-029 counted from the second run.
REQ-033 rst pulsed at round 40 -> out0..7=0 and done=1 immediately; stays IDLE with no later done edge.
REQ-034 Two jobs chained, run on FIN-entry cycle, second job with in0..7=first digest and in8=all-zero W -> second result matches the software model; done low exactly 64 cycles.
